// File: rtl/id_stage_param_pkg.sv
// Shared decode constants, control bundle layout and the main/ALU-function decoders
// for the parametrised decode stage.
package id_stage_param_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] BYP_RF  = 2'd0;
  localparam logic [1:0] BYP_EX  = 2'd1;
  localparam logic [1:0] BYP_MEM = 2'd2;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_EQ   = 2'd1;
  localparam logic [1:0] BR_NE   = 2'd2;

  localparam int unsigned EX_R_FORMAT   = 0;
  localparam int unsigned EX_ALU_SRC    = 1;
  localparam int unsigned MEM_READ      = 0;
  localparam int unsigned MEM_WRITE     = 1;
  localparam int unsigned MEM_BR_LO     = 2;
  localparam int unsigned WB_MEM_TO_REG = 0;
  localparam int unsigned WB_REG_WRITE  = 1;

  typedef struct packed {
    logic       r_format;
    logic       alu_src_imm;
    logic [1:0] branch_op;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       mem_to_reg;
    logic       rs_used;
    logic       rt_used;
    logic       zext_imm;
  } ctrl_t;

  function automatic ctrl_t main_ctrl_dec(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.r_format = 1'b1; c.reg_write = 1'b1; c.rs_used = 1'b1; c.rt_used = 1'b1;
      end
      OP_LW: begin
        c.alu_src_imm = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1;
        c.mem_to_reg = 1'b1; c.rs_used = 1'b1;
      end
      OP_SW: begin
        c.alu_src_imm = 1'b1; c.mem_write = 1'b1; c.rs_used = 1'b1; c.rt_used = 1'b1;
      end
      OP_BEQ: begin c.branch_op = BR_EQ; c.rs_used = 1'b1; c.rt_used = 1'b1; end
      OP_BNE: begin c.branch_op = BR_NE; c.rs_used = 1'b1; c.rt_used = 1'b1; end
      OP_ADDI, OP_SLTI: begin
        c.alu_src_imm = 1'b1; c.reg_write = 1'b1; c.rs_used = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        c.alu_src_imm = 1'b1; c.reg_write = 1'b1; c.rs_used = 1'b1; c.zext_imm = 1'b1;
      end
      // lui reads no register; the rs field is don't-care
      OP_LUI: begin c.alu_src_imm = 1'b1; c.reg_write = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] alu_funct_dec(input logic [5:0] opcode, input logic [5:0] funct);
    logic [3:0] f;
    f = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SUB:   f = ALU_SUB;
          F_AND:   f = ALU_AND;
          F_OR:    f = ALU_OR;
          F_XOR:   f = ALU_XOR;
          F_NOR:   f = ALU_NOR;
          F_SLT:   f = ALU_SLT;
          default: f = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: f = ALU_SUB;
      OP_SLTI:        f = ALU_SLT;
      OP_ANDI:        f = ALU_AND;
      OP_ORI:         f = ALU_OR;
      OP_XORI:        f = ALU_XOR;
      OP_LUI:         f = ALU_LUI;
      default:        f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/id_hazard_bypass.sv
// Forwarding-select and load-use interlock for the two decode-stage sources.
module id_hazard_bypass
  import id_stage_param_pkg::*;
#(
  parameter int unsigned AW              = 5,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned ZERO_REG        = 1
) (
  input  logic          in_valid,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic          rs_used,
  input  logic          rt_used,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_is_load,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_is_load,
  output logic [1:0]    bypass1,
  output logic [1:0]    bypass2,
  output logic          hazard_stall
);

  logic rs_live, rt_live;
  logic ld_rs, ld_rt;

  // r0 is hardwired when ZERO_REG, so it never forwards or interlocks
  assign rs_live = (ZERO_REG == 0) || (rs != '0);
  assign rt_live = (ZERO_REG == 0) || (rt != '0);

  assign bypass1 = (ex_we && ex_rd == rs && rs_live)   ? BYP_EX  :
                   (mem_we && mem_rd == rs && rs_live) ? BYP_MEM : BYP_RF;
  assign bypass2 = (ex_we && ex_rd == rt && rt_live)   ? BYP_EX  :
                   (mem_we && mem_rd == rt && rt_live) ? BYP_MEM : BYP_RF;

  assign ld_rs = rs_used && rs_live &&
                 ((ex_is_load && ex_rd == rs) ||
                  (LOAD_USE_CYCLES == 2 && mem_is_load && mem_rd == rs));
  assign ld_rt = rt_used && rt_live &&
                 ((ex_is_load && ex_rd == rt) ||
                  (LOAD_USE_CYCLES == 2 && mem_is_load && mem_rd == rt));

  assign hazard_stall = in_valid && (ld_rs || ld_rt);

endmodule

// File: rtl/id_stage_param.sv
// Decode stage: register file with write-through, instruction decode, hazard/bypass
// selection and the ID/EX pipeline register.
module id_stage_param
  import id_stage_param_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned NREGS           = 32,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned ZERO_REG        = 1,
  localparam int unsigned AW             = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            in_prediction,
  input  logic            flush,
  input  logic            cache_stall,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_we,
  input  logic [AW-1:0]   ex_rd,
  input  logic            ex_is_load,
  input  logic            mem_we,
  input  logic [AW-1:0]   mem_rd,
  input  logic            mem_is_load,
  output logic            hazard_stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs_data,
  output logic [XLEN-1:0] out_rt_data,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rt,
  output logic [AW-1:0]   out_rd,
  output logic [1:0]      out_bypass1,
  output logic [1:0]      out_bypass2,
  output logic [3:0]      out_alu_funct,
  output logic [1:0]      out_ex_ctrl,
  output logic [3:0]      out_mem_ctrl,
  output logic [1:0]      out_wb_ctrl,
  output logic            out_prediction
);

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   rs, rt, rd;
  logic [15:0]     imm16;
  logic [XLEN-1:0] imm, rs_data, rt_data;
  ctrl_t           dec;
  logic [3:0]      alu_funct;
  logic [1:0]      ex_ctrl, wb_ctrl, bypass1, bypass2;
  logic [3:0]      mem_ctrl;
  logic [4:0]      unused_shamt;

  assign rs    = in_instr[21 +: AW];
  assign rt    = in_instr[16 +: AW];
  assign rd    = in_instr[11 +: AW];
  assign imm16 = in_instr[15:0];
  assign unused_shamt = in_instr[10:6];

  assign dec       = main_ctrl_dec(in_instr[31:26]);
  assign alu_funct = alu_funct_dec(in_instr[31:26], in_instr[5:0]);
  assign imm = dec.zext_imm ? {{(XLEN-16){1'b0}}, imm16} : {{(XLEN-16){imm16[15]}}, imm16};

  always_comb begin
    ex_ctrl = '0;
    ex_ctrl[EX_R_FORMAT] = dec.r_format;
    ex_ctrl[EX_ALU_SRC]  = dec.alu_src_imm;
    mem_ctrl = '0;
    mem_ctrl[MEM_READ]             = dec.mem_read;
    mem_ctrl[MEM_WRITE]            = dec.mem_write;
    mem_ctrl[MEM_BR_LO +: 2]       = dec.branch_op;
    wb_ctrl = '0;
    wb_ctrl[WB_MEM_TO_REG] = dec.mem_to_reg;
    wb_ctrl[WB_REG_WRITE]  = dec.reg_write;
  end

  // Same-cycle writeback is forwarded so the ID/EX register latches the new value
  always_comb begin
    rs_data = regs[rs];
    if (wb_we && wb_rd == rs) rs_data = wb_data;
    if (ZERO_REG != 0 && rs == '0) rs_data = '0;
    rt_data = regs[rt];
    if (wb_we && wb_rd == rt) rt_data = wb_data;
    if (ZERO_REG != 0 && rt == '0) rt_data = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && !(ZERO_REG != 0 && wb_rd == '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  id_hazard_bypass #(
    .AW              (AW),
    .LOAD_USE_CYCLES (LOAD_USE_CYCLES),
    .ZERO_REG        (ZERO_REG)
  ) u_hazard_bypass (
    .in_valid     (in_valid),
    .rs           (rs),
    .rt           (rt),
    .rs_used      (dec.rs_used),
    .rt_used      (dec.rt_used),
    .ex_we        (ex_we),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .mem_we       (mem_we),
    .mem_rd       (mem_rd),
    .mem_is_load  (mem_is_load),
    .bypass1      (bypass1),
    .bypass2      (bypass2),
    .hazard_stall (hazard_stall)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_rs_data    <= '0;
      out_rt_data    <= '0;
      out_imm        <= '0;
      out_rt         <= '0;
      out_rd         <= '0;
      out_bypass1    <= '0;
      out_bypass2    <= '0;
      out_alu_funct  <= '0;
      out_ex_ctrl    <= '0;
      out_mem_ctrl   <= '0;
      out_wb_ctrl    <= '0;
      out_prediction <= 1'b0;
    end else if (cache_stall) begin
      // global freeze: hold everything
    end else if (hazard_stall) begin
      out_valid      <= 1'b0;
      out_alu_funct  <= '0;
      out_ex_ctrl    <= '0;
      out_mem_ctrl   <= '0;
      out_wb_ctrl    <= '0;
      out_prediction <= 1'b0;
    end else begin
      out_valid      <= in_valid;
      out_pc         <= in_pc;
      out_rs_data    <= rs_data;
      out_rt_data    <= rt_data;
      out_imm        <= imm;
      out_rt         <= rt;
      out_rd         <= rd;
      out_bypass1    <= bypass1;
      out_bypass2    <= bypass2;
      out_alu_funct  <= in_valid ? alu_funct : 4'd0;
      out_ex_ctrl    <= in_valid ? ex_ctrl : 2'd0;
      out_mem_ctrl   <= in_valid ? mem_ctrl : 4'd0;
      out_wb_ctrl    <= in_valid ? wb_ctrl : 2'd0;
      out_prediction <= in_valid & in_prediction;
    end
  end

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: one instance with single-cycle load interlock,
// one with two-cycle interlock, both driven by the same stimulus.
module tb_id_stage_param;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_prediction, flush, cache_stall;
  logic [31:0] in_pc, in_instr, wb_data;
  logic        wb_we, ex_we, ex_is_load, mem_we, mem_is_load;
  logic [4:0]  wb_rd, ex_rd, mem_rd;

  logic        hz_a, v_a, pred_a, hz_b, v_b, pred_b;
  logic [31:0] pc_a, rsd_a, rtd_a, imm_a, pc_b, rsd_b, rtd_b, imm_b;
  logic [4:0]  rt_a, rd_a, rt_b, rd_b;
  logic [1:0]  by1_a, by2_a, exc_a, wbc_a, by1_b, by2_b, exc_b, wbc_b;
  logic [3:0]  alu_a, memc_a, alu_b, memc_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_stage_param #(.LOAD_USE_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_prediction(in_prediction), .flush(flush), .cache_stall(cache_stall),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_is_load(mem_is_load),
    .hazard_stall(hz_a), .out_valid(v_a), .out_pc(pc_a), .out_rs_data(rsd_a),
    .out_rt_data(rtd_a), .out_imm(imm_a), .out_rt(rt_a), .out_rd(rd_a),
    .out_bypass1(by1_a), .out_bypass2(by2_a), .out_alu_funct(alu_a),
    .out_ex_ctrl(exc_a), .out_mem_ctrl(memc_a), .out_wb_ctrl(wbc_a), .out_prediction(pred_a)
  );

  id_stage_param #(.LOAD_USE_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_prediction(in_prediction), .flush(flush), .cache_stall(cache_stall),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_is_load(mem_is_load),
    .hazard_stall(hz_b), .out_valid(v_b), .out_pc(pc_b), .out_rs_data(rsd_b),
    .out_rt_data(rtd_b), .out_imm(imm_b), .out_rt(rt_b), .out_rd(rd_b),
    .out_bypass1(by1_b), .out_bypass2(by2_b), .out_alu_funct(alu_b),
    .out_ex_ctrl(exc_b), .out_mem_ctrl(memc_b), .out_wb_ctrl(wbc_b), .out_prediction(pred_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_fwd();
    ex_we = 0; ex_rd = 0; ex_is_load = 0;
    mem_we = 0; mem_rd = 0; mem_is_load = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_pc = 0; in_instr = 0; in_prediction = 0;
    flush = 0; cache_stall = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    clear_fwd();
    step(); step();
    check("rst_valid", {31'd0, v_a}, 32'd0);
    check("rst_pc", pc_a, 32'd0);
    check("rst_alu", {28'd0, alu_a}, 32'd0);
    check("rst_wb", {30'd0, wbc_a}, 32'd0);

    // write-through: add r1 = r5 + r6 while r5 is being written back
    reset = 0; in_valid = 1; in_pc = 32'h104; in_instr = r_ins(5, 6, 1, 6'h20);
    wb_we = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF;
    step();
    wb_we = 0;
    check("wt_rs_data", rsd_a, 32'hDEAD_BEEF);
    check("wt_rt_data", rtd_a, 32'd0);
    check("wt_valid", {31'd0, v_a}, 32'd1);
    check("wt_pc", pc_a, 32'h104);
    check("add_alu", {28'd0, alu_a}, 32'd2);
    check("add_ex", {30'd0, exc_a}, 32'd1);
    check("add_wb", {30'd0, wbc_a}, 32'd2);
    check("add_rd", {27'd0, rd_a}, 32'd1);

    // load-use on rt
    in_pc = 32'h108; in_instr = r_ins(5, 3, 2, 6'h20);
    ex_we = 1; ex_rd = 3; ex_is_load = 1;
    settle();
    check("lu_stall", {31'd0, hz_a}, 32'd1);
    step();
    check("lu_bub_valid", {31'd0, v_a}, 32'd0);
    check("lu_bub_ex", {30'd0, exc_a}, 32'd0);
    check("lu_bub_wb", {30'd0, wbc_a}, 32'd0);
    check("lu_hold_pc", pc_a, 32'h104);
    check("lu_hold_rd", {27'd0, rd_a}, 32'd1);
    clear_fwd(); mem_we = 1; mem_rd = 3;
    settle();
    check("lu_release", {31'd0, hz_a}, 32'd0);
    step();
    check("lu_adv_valid", {31'd0, v_a}, 32'd1);
    check("lu_adv_pc", pc_a, 32'h108);
    check("lu_byp2_mem", {30'd0, by2_a}, 32'd2);
    check("lu_byp1_rf", {30'd0, by1_a}, 32'd0);
    check("lu_rf_keep", rsd_a, 32'hDEAD_BEEF);

    // lui does not read rs, so a load to its rs field must not interlock
    clear_fwd(); in_pc = 32'h10c; in_instr = i_ins(6'h0f, 9, 8, 16'h1234);
    ex_we = 1; ex_rd = 9; ex_is_load = 1;
    settle();
    check("lui_nostall", {31'd0, hz_a}, 32'd0);
    step();
    check("lui_valid", {31'd0, v_a}, 32'd1);
    check("lui_imm", imm_a, 32'h0000_1234);
    check("lui_alu", {28'd0, alu_a}, 32'd4);

    // load to r0 with ZERO_REG: no stall, no bypass
    in_pc = 32'h110; in_instr = r_ins(0, 0, 4, 6'h20); ex_rd = 0;
    settle();
    check("r0_nostall", {31'd0, hz_a}, 32'd0);
    step();
    check("r0_valid", {31'd0, v_a}, 32'd1);
    check("r0_byp1", {30'd0, by1_a}, 32'd0);
    check("r0_byp2", {30'd0, by2_a}, 32'd0);

    // EX beats MEM; addi sign-extends
    clear_fwd(); ex_we = 1; ex_rd = 7; mem_we = 1; mem_rd = 7;
    in_pc = 32'h114; in_instr = i_ins(6'h08, 7, 10, 16'h8000);
    step();
    check("prio_byp1_ex", {30'd0, by1_a}, 32'd1);
    check("addi_imm", imm_a, 32'hFFFF_8000);
    check("addi_ex", {30'd0, exc_a}, 32'd2);

    // ori zero-extends
    clear_fwd(); in_pc = 32'h120; in_instr = i_ins(6'h0d, 1, 11, 16'h8000);
    step();
    check("ori_imm", imm_a, 32'h0000_8000);
    check("ori_alu", {28'd0, alu_a}, 32'd1);
    check("ori_byp1", {30'd0, by1_a}, 32'd0);

    // cache_stall with a pending load-use: everything frozen
    cache_stall = 1; ex_we = 1; ex_is_load = 1; ex_rd = 1;
    in_pc = 32'h200; in_instr = r_ins(1, 2, 3, 6'h20);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("frz_stall", {31'd0, hz_a}, 32'd1);
      step();
      check("frz_pc", pc_a, 32'h120);
      check("frz_valid", {31'd0, v_a}, 32'd1);
      check("frz_imm", imm_a, 32'h0000_8000);
    end
    cache_stall = 0; flush = 1;
    settle();
    check("fl_stall_hi", {31'd0, hz_a}, 32'd1);
    step();
    check("fl_valid", {31'd0, v_a}, 32'd0);
    check("fl_pc", pc_a, 32'd0);
    check("fl_imm", imm_a, 32'd0);

    // writes to r0 are dropped
    flush = 0; clear_fwd();
    wb_we = 1; wb_rd = 0; wb_data = 32'h1234;
    in_pc = 32'h300; in_instr = r_ins(0, 0, 5, 6'h20);
    step();
    check("r0_wt", rsd_a, 32'd0);
    wb_we = 0;
    step();
    check("r0_stored", rsd_a, 32'd0);

    // load in MEM: only the two-cycle variant interlocks
    mem_we = 1; mem_rd = 4; mem_is_load = 1;
    in_pc = 32'h304; in_instr = r_ins(4, 1, 6, 6'h20);
    settle();
    check("luc1_nostall", {31'd0, hz_a}, 32'd0);
    check("luc2_stall", {31'd0, hz_b}, 32'd1);
    step();
    check("luc1_valid", {31'd0, v_a}, 32'd1);
    check("luc1_byp1_mem", {30'd0, by1_a}, 32'd2);
    check("luc2_bubble", {31'd0, v_b}, 32'd0);
    clear_fwd();
    settle();
    check("luc2_release", {31'd0, hz_b}, 32'd0);
    step();
    check("luc2_valid", {31'd0, v_b}, 32'd1);
    check("luc2_pc", pc_b, 32'h304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
